// File: rtl/omsp_spm_cmd_issuer.sv
// omsp_spm_cmd_issuer
// Initiator side of the SPM update interface. Takes one protect/unprotect command at a time
// from the execution unit, validates the latched layout, fires a single-cycle update request
// into the SPM control array, waits a settle interval and returns done with a status code.
//
// Optional feature: define SPM_CMD_ALIGN_CHECK_EN to reject protect commands whose bounds are
// not 16-bit aligned (status 11). Without it, status 11 is never produced.
//
// Ports
//   mclk, puc_rst            clock, synchronous active-high reset
//   cmd_valid, cmd_protect   command request (sampled while cmd_ready), 1=protect 0=unprotect
//   r12..r15                 layout: public start/end, secret start/end (ends exclusive)
//   spm_free                 at least one SPM slot is disabled (sampled in CHECK only)
//   cmd_ready                idle, command can be accepted
//   update_spm, enable_spm   one-cycle update request, enable_spm = 1 create / 0 disable
//   lay_r12..lay_r15         latched layout
//   done, status             one-cycle completion pulse, 00 ok / 01 layout / 10 no slot / 11 align
module omsp_spm_cmd_issuer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        cmd_valid,
  input  logic        cmd_protect,
  input  logic [15:0] r12,
  input  logic [15:0] r13,
  input  logic [15:0] r14,
  input  logic [15:0] r15,
  input  logic        spm_free,
  output logic        cmd_ready,
  output logic        update_spm,
  output logic        enable_spm,
  output logic [15:0] lay_r12,
  output logic [15:0] lay_r13,
  output logic [15:0] lay_r14,
  output logic [15:0] lay_r15,
  output logic        done,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StSettle, StDone} state_e;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusLayout  = 2'b01;
  localparam logic [1:0] StatusNoFree  = 2'b10;
  localparam logic [1:0] StatusAlign   = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       status_q, status_d;
  logic             prot_q;
  logic [15:0]      lay_r12_q, lay_r13_q, lay_r14_q, lay_r15_q;
  logic             accept;
  logic [1:0]       err_code;
  logic             layout_ok;

  assign accept = (state_q == StIdle) && cmd_valid;

  // Ranges are half-open, so touching ranges (end == start) do not overlap.
  assign layout_ok = (lay_r12_q < lay_r13_q) && (lay_r14_q < lay_r15_q) &&
                     ((lay_r13_q <= lay_r14_q) || (lay_r15_q <= lay_r12_q));

  always_comb begin
    err_code = StatusOk;
    if (prot_q) begin
`ifdef SPM_CMD_ALIGN_CHECK_EN
      if (lay_r12_q[0] | lay_r13_q[0] | lay_r14_q[0] | lay_r15_q[0]) begin
        err_code = StatusAlign;
      end else
`endif
      if (!layout_ok) begin
        err_code = StatusLayout;
      end else if (!spm_free) begin
        err_code = StatusNoFree;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StCheck;
      end
      StCheck: begin
        status_d = err_code;
        state_d  = (err_code == StatusOk) ? StIssue : StDone;
      end
      StIssue: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      status_q  <= StatusOk;
      prot_q    <= 1'b0;
      lay_r12_q <= '0;
      lay_r13_q <= '0;
      lay_r14_q <= '0;
      lay_r15_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      if (accept) begin
        prot_q    <= cmd_protect;
        lay_r12_q <= r12;
        lay_r13_q <= r13;
        lay_r14_q <= r14;
        lay_r15_q <= r15;
      end
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign update_spm = (state_q == StIssue);
  assign enable_spm = (state_q == StIssue) && prot_q;
  assign done       = (state_q == StDone);
  assign status     = status_q;
  assign lay_r12    = lay_r12_q;
  assign lay_r13    = lay_r13_q;
  assign lay_r14    = lay_r14_q;
  assign lay_r15    = lay_r15_q;

endmodule

// File: tb/tb_omsp_spm_cmd_issuer.sv
module tb_omsp_spm_cmd_issuer;

  localparam int unsigned S = 2;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        cmd_valid;
  logic        cmd_protect;
  logic [15:0] r12, r13, r14, r15;
  logic        spm_free;
  logic        cmd_ready, update_spm, enable_spm, done;
  logic [15:0] lay_r12, lay_r13, lay_r14, lay_r15;
  logic [1:0]  status;

  always #5 mclk = ~mclk;

  omsp_spm_cmd_issuer #(
    .SETTLE_CYCLES(S),
    .CNT_W        (4)
  ) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .cmd_valid  (cmd_valid),
    .cmd_protect(cmd_protect),
    .r12        (r12),
    .r13        (r13),
    .r14        (r14),
    .r15        (r15),
    .spm_free   (spm_free),
    .cmd_ready  (cmd_ready),
    .update_spm (update_spm),
    .enable_spm (enable_spm),
    .lay_r12    (lay_r12),
    .lay_r13    (lay_r13),
    .lay_r14    (lay_r14),
    .lay_r15    (lay_r15),
    .done       (done),
    .status     (status)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules for the status of a protect command, before the spm_free check.
  function automatic logic [1:0] layout_code(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d);
`ifdef SPM_CMD_ALIGN_CHECK_EN
    if (a[0] || b[0] || c[0] || d[0]) return 2'b11;
`endif
    if (!(a < b && c < d && (b <= c || d <= a))) return 2'b01;
    return 2'b00;
  endfunction

  // Transaction-level model: one command in flight, timed by its offset from accept.
  bit          mon_en = 0;
  bit          m_busy = 0;
  int          m_k = 0;
  int          m_done_k = 99;
  bit          m_prot = 0;
  logic [1:0]  m_code = 2'b00;
  logic [1:0]  m_status = 2'b00;
  logic [15:0] m_lay [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  always @(negedge mclk) begin
    if (mon_en) begin
      bit exp_upd, exp_done;
      if (m_busy && m_k == 1) begin
        if (m_prot && m_code == 2'b00 && !spm_free) m_code = 2'b10;
        m_done_k = (m_code == 2'b00) ? 3 + int'(S) : 2;
      end
      exp_upd  = m_busy && m_code == 2'b00 && m_k == 2;
      exp_done = m_busy && m_k == m_done_k;
      chk("m_cmd_ready", cmd_ready, !m_busy);
      chk("m_update_spm", update_spm, exp_upd);
      chk("m_done", done, exp_done);
      if (exp_upd) chk("m_enable_spm", enable_spm, m_prot);
      if (exp_done) chk("m_status_done", status, m_code);
      else if (!m_busy) chk("m_status_idle", status, m_status);
      chk("m_lay_r12", lay_r12, m_lay[0]);
      chk("m_lay_r13", lay_r13, m_lay[1]);
      chk("m_lay_r14", lay_r14, m_lay[2]);
      chk("m_lay_r15", lay_r15, m_lay[3]);
      if (puc_rst) begin
        m_busy   = 0;
        m_status = 2'b00;
        m_lay    = '{16'h0, 16'h0, 16'h0, 16'h0};
      end else if (m_busy) begin
        if (m_k == m_done_k) begin
          m_busy   = 0;
          m_status = m_code;
        end else begin
          m_k++;
        end
      end else if (cmd_valid) begin
        m_busy   = 1;
        m_k      = 1;
        m_done_k = 99;
        m_prot   = cmd_protect;
        m_lay    = '{r12, r13, r14, r15};
        m_code   = cmd_protect ? layout_code(r12, r13, r14, r15) : 2'b00;
      end
    end
  end

  task automatic step;
    @(posedge mclk);
    #1;
  endtask

  // Issue one command from idle and watch it complete; expectations are literals.
  task automatic run_cmd(input string name, input bit prot, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c, input logic [15:0] d,
                         input bit free, input logic [1:0] exp_st, input int exp_lat,
                         input int exp_upd_k);
    int upd_at, done_at, k;
    logic [1:0]  st;
    logic [15:0] l12;
    upd_at = -1; done_at = -1; st = 2'bxx; l12 = 16'hxxxx;
    cmd_valid = 1; cmd_protect = prot; r12 = a; r13 = b; r14 = c; r15 = d; spm_free = free;
    step();
    cmd_valid = 0;
    cmd_protect = 1'($urandom);
    r12 = 16'($urandom); r13 = 16'($urandom); r14 = 16'($urandom); r15 = 16'($urandom);
    k = 1;
    while (k <= 20 && done_at < 0) begin
      @(negedge mclk);
      if (update_spm && upd_at < 0) upd_at = k;
      if (done) begin
        done_at = k;
        st      = status;
        l12     = lay_r12;
      end
      step();
      spm_free = 1'($urandom);
      k++;
    end
    chk({name, " latency"}, done_at, exp_lat);
    chk({name, " status"}, {30'd0, st}, {30'd0, exp_st});
    chk({name, " update_at"}, upd_at, exp_upd_k);
    chk({name, " lay_r12"}, {16'd0, l12}, {16'd0, a});
  endtask

  initial begin
    int n_upd, n_done, second_acc, acc_cnt;
    puc_rst = 1; cmd_valid = 0; cmd_protect = 0;
    r12 = 0; r13 = 0; r14 = 0; r15 = 0; spm_free = 0;
    step();
    step();
    mon_en = 1;
    @(negedge mclk);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset update_spm", update_spm, 0);
    chk("reset done", done, 0);
    chk("reset status", status, 0);
    chk("reset lay_r12", lay_r12, 0);
    step();
    puc_rst = 0;

    run_cmd("ok_protect", 1, 16'h6000, 16'h6100, 16'h0300, 16'h0380, 1, 2'b00, 5, 2);
    run_cmd("empty_range", 1, 16'h6000, 16'h6000, 16'h0300, 16'h0380, 1, 2'b01, 2, -1);
    run_cmd("overlap", 1, 16'h6000, 16'h6100, 16'h6080, 16'h6200, 1, 2'b01, 2, -1);
    run_cmd("no_free", 1, 16'h6000, 16'h6100, 16'h0300, 16'h0380, 0, 2'b10, 2, -1);
    run_cmd("unprotect", 0, 16'h6000, 16'h6100, 16'h0300, 16'h0380, 0, 2'b00, 5, 2);
`ifdef SPM_CMD_ALIGN_CHECK_EN
    run_cmd("misaligned", 1, 16'h6001, 16'h6100, 16'h0300, 16'h0380, 1, 2'b11, 2, -1);
    run_cmd("misaligned_bad", 1, 16'h6001, 16'h6000, 16'h0300, 16'h0380, 0, 2'b11, 2, -1);
`else
    run_cmd("odd_bound", 1, 16'h6001, 16'h6100, 16'h0300, 16'h0380, 1, 2'b00, 5, 2);
`endif
    run_cmd("touching", 1, 16'h0100, 16'h0200, 16'h0200, 16'h0300, 1, 2'b00, 5, 2);

    // Reset in the middle of SETTLE.
    cmd_valid = 1; cmd_protect = 1; spm_free = 1;
    r12 = 16'h6000; r13 = 16'h6100; r14 = 16'h0300; r15 = 16'h0380;
    step();
    cmd_valid = 0;
    step();
    step();
    puc_rst = 1;
    step();
    puc_rst = 0;
    @(negedge mclk);
    chk("rst_settle cmd_ready", cmd_ready, 1);
    n_done = 0; n_upd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      n_done += int'(done);
      n_upd  += int'(update_spm);
    end
    chk("rst_settle done_count", n_done, 0);
    chk("rst_settle update_count", n_upd, 0);
    step();

    // Back-to-back: cmd_valid held high through the second accept.
    cmd_valid = 1; cmd_protect = 1; spm_free = 1;
    r12 = 16'h1000; r13 = 16'h1100; r14 = 16'h2000; r15 = 16'h2040;
    n_upd = 0; n_done = 0; second_acc = -1; acc_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge mclk);
      n_upd  += int'(update_spm);
      n_done += int'(done);
      if (cmd_ready && cmd_valid) begin
        acc_cnt++;
        if (acc_cnt == 2) second_acc = c;
      end
      step();
      if (c == 6) cmd_valid = 0;
    end
    chk("b2b update_count", n_upd, 2);
    chk("b2b done_count", n_done, 2);
    chk("b2b second_accept", second_acc, 6);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      puc_rst     = ($urandom % 80) == 0;
      cmd_valid   = ($urandom % 3) == 0;
      cmd_protect = ($urandom % 4) != 0;
      r12 = 16'($urandom_range(0, 63));
      r13 = 16'($urandom_range(0, 63));
      r14 = 16'($urandom_range(0, 63));
      r15 = 16'($urandom_range(0, 63));
      if (($urandom % 4) != 0) begin
        r12[0] = 0; r13[0] = 0; r14[0] = 0; r15[0] = 0;
      end
      if (($urandom % 8) == 0) r15 = 16'($urandom);
      spm_free = ($urandom % 4) != 0;
      step();
    end
    puc_rst = 0; cmd_valid = 0;
    for (int i = 0; i < 12; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
